adc_spi_master: RTL
===================

ADC_SPI_MASTER -- requirements
Module: adc_spi_master

Interface
REQ-001 Parameter DIVISOR, default 13: sclk period in clock_in cycles; legal range 4..255.
REQ-002 Parameter EOC_TIMEOUT, default 1000000: maximum clock_in cycles spent waiting for end-of-conversion.
REQ-003 clock_in  input  1: single system clock; all state on its rising edge.
REQ-004 reset_n  input  1: asynchronous assert, active-low reset.
REQ-005 start  input  1: one-cycle transaction request, honoured only while busy=0.
REQ-006 cmd  input  16: ADC configuration word, sent MSB first.
REQ-007 miso  input  1: serial data from the ADC; low while cs_n=0 signals conversion complete.
REQ-008 sclk  output  1: serial clock, idle low.
REQ-009 cs_n  output  1: chip select, active low.
REQ-010 mosi  output  1: serial data to the ADC.
REQ-011 busy  output  1: high from the cycle after an accepted start until the cycle after done.
REQ-012 done  output  1: one-cycle pulse at transaction end.
REQ-013 timeout  output  1: valid with done; 1 = EOC wait expired, no frame clocked.
REQ-014 data_out  output  24: last received frame, MSB = first bit received.

Function
REQ-015 FSM states IDLE, WAIT_EOC, SHIFT, FINISH; encoding is free.
REQ-016 IDLE: cs_n=1, sclk=0, mosi=0, busy=0; start=1 latches {cmd,8'h00} into a 24-bit transmit register and enters WAIT_EOC next cycle.
REQ-017 WAIT_EOC: cs_n=0, sclk=0, busy=1; miso passes through a 2-flop synchroniser; synchronised miso=0 enters SHIFT next cycle.
REQ-018 WAIT_EOC: a cycle counter reaching EOC_TIMEOUT enters FINISH with timeout flag set; data_out unchanged.
REQ-019 SHIFT: 24 sclk periods of DIVISOR cycles each; low phase DIVISOR-DIVISOR/2 cycles first, then high phase DIVISOR/2 cycles.
REQ-020 SHIFT: mosi presents transmit bit 23-k on the first low-phase cycle of period k (k=0..23) and holds it through that period.
REQ-021 SHIFT: raw miso is sampled into the receive shift register on the clock_in edge where sclk rises (no synchroniser in this path).
REQ-022 SHIFT: after the high phase of period 23, sclk returns low and the FSM enters FINISH.
REQ-023 FINISH: cs_n=1, sclk=0, done=1 for exactly one cycle, data_out loaded with receive register unless timeout; timeout output equals the flag; next state IDLE.
REQ-024 timeout output is held until the next done pulse.
REQ-025 start while busy=1 or in FINISH is ignored, no queuing.
REQ-026 Period counter width 8 bits, bit counter 5 bits; neither wraps within a transaction.
REQ-027 Odd DIVISOR: low phase is one cycle longer than high phase (13 -> 7 low, 6 high).

Reset
REQ-028 reset_n=0 immediately forces IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, timeout=0, data_out=24'h000000, all counters and shift registers zero.
REQ-029 Reset mid-transaction aborts it with no done pulse; cs_n rises asynchronously.
REQ-030 After reset release, first start is accepted on the first clock edge with reset_n=1.

Verification
REQ-031 DIVISOR=13, cmd=16'hB800, miso low at start, ADC model returns 24'hA5C3F0 -> mosi stream B8 00 00, exactly 24 sclk rises, 7 low/6 high cycles, done one cycle, data_out=24'hA5C3F0, timeout=0.
REQ-032 miso held high 500 cycles then low -> cs_n low throughout, sclk static low during wait, frame completes normally.
REQ-033 EOC_TIMEOUT=50, miso held high -> done at cycle ~50 after entering WAIT_EOC, timeout=1, zero sclk edges, data_out keeps previous value.
REQ-034 start pulsed again during SHIFT -> ignored; exactly one done; next start after done accepted.
REQ-035 reset_n low at sclk rise 10 -> cs_n=1, sclk=0 same cycle, no done, data_out=0; new transaction afterwards correct.
REQ-036 DIVISOR=4 back-to-back transactions, miso toggling pattern 24'h555555 -> data_out=24'h555555, 2 low/2 high cycles, busy low exactly one cycle between transactions.

Source files
------------

// File: rtl/adc_spi_master.sv
// SPI master for a conversion-type ADC: waits for end-of-conversion on miso,
// then clocks a 24-bit frame out on mosi while capturing 24 bits from miso.
module adc_spi_master #(
  parameter int unsigned DIVISOR     = 13,
  parameter int unsigned EOC_TIMEOUT = 1000000
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic        miso,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [23:0] data_out
);

  localparam logic [7:0]  LOW_LEN  = 8'(DIVISOR - DIVISOR / 2);
  localparam logic [7:0]  DIV_LAST = 8'(DIVISOR - 1);
  localparam int unsigned EW       = $clog2(EOC_TIMEOUT + 1);
  localparam logic [EW-1:0] EOC_LAST = EW'(EOC_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_EOC, SHIFT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [23:0]   tx_q, tx_d;
  logic [23:0]   rx_q, rx_d;
  logic [7:0]    div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [EW-1:0] eoc_q, eoc_d;
  logic [1:0]    sync_q, sync_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [23:0]   data_q, data_d;

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    div_d     = div_q;
    bit_d     = bit_q;
    eoc_d     = eoc_q;
    sync_d    = {sync_q[0], miso};
    timeout_d = timeout_q;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = {cmd, 8'h00};
          eoc_d   = '0;
          state_d = WAIT_EOC;
        end
      end
      WAIT_EOC: begin
        if (!sync_q[1]) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end else if (eoc_q == EOC_LAST) begin
          state_d   = FINISH;
          timeout_d = 1'b1;
        end else begin
          eoc_d = eoc_q + EW'(1);
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          tx_d  = {tx_q[22:0], 1'b0};
          if (bit_q == 5'd23) begin
            state_d   = FINISH;
            timeout_d = 1'b0;
            data_d    = rx_q;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
          // Raw miso is captured on the same edge that drives sclk high.
          if (div_d == LOW_LEN) rx_d = {rx_q[22:0], miso};
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered from next-state values so they change
    // on the same edge as the state, glitch-free.
    cs_n_d = !((state_d == WAIT_EOC) || (state_d == SHIFT));
    sclk_d = (state_d == SHIFT) && (div_d >= LOW_LEN);
    mosi_d = (state_d == SHIFT) ? tx_d[23] : 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      eoc_q     <= '0;
      sync_q    <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      eoc_q     <= eoc_d;
      sync_q    <= sync_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      data_q    <= data_d;
    end
  end

  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign data_out = data_q;

endmodule
